// File: rtl/cache_pkg.sv
// Shared defaults and FSM encoding for the cache tag fill controller.
// Imported by the interface, the LRU helper and the top.
package cache_pkg;

    localparam int TagBitsDef   = 12;
    localparam int IndexBitsDef = 4;
    localparam int WaysDef      = 4;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EVICT,
        WRITE,
        DONE
    } fillState_e;

endpackage

// File: rtl/tag_fill_controller_if.sv
// Fill request / eviction handshake bundle between the miss logic
// and the tag fill controller.
interface tag_fill_controller_if
    import cache_pkg::*;
#(
    parameter int tagBits   = TagBitsDef,
    parameter int indexBits = IndexBitsDef,
    parameter int ways      = WaysDef
);
    localparam int wayBits = $clog2(ways);

    logic                 fillReq;
    logic [tagBits-1:0]   fillTag;
    logic [indexBits-1:0] fillIndex;
    logic                 fillDirty;
    logic                 fillReady;
    logic                 fillDone;
    logic [wayBits-1:0]   fillWay;
    logic                 evictValid;
    logic [tagBits-1:0]   evictTag;
    logic [indexBits-1:0] evictIndex;
    logic                 evictReady;

    modport master (
        output fillReq, fillTag, fillIndex, fillDirty, evictReady,
        input  fillReady, fillDone, fillWay,
        input  evictValid, evictTag, evictIndex
    );

    modport slave (
        input  fillReq, fillTag, fillIndex, fillDirty, evictReady,
        output fillReady, fillDone, fillWay,
        output evictValid, evictTag, evictIndex
    );

endinterface

// File: rtl/lru_age_update.sv
// Age update for one set: touched way becomes 0, younger ways age by one,
// so the ages stay a permutation of 0..ways-1.
module lru_age_update
    import cache_pkg::*;
#(
    parameter int ways = WaysDef,
    localparam int wayBits = $clog2(ways)
) (
    input  logic [ways-1:0][wayBits-1:0] ages,
    input  logic [wayBits-1:0]           touchWay,
    output logic [ways-1:0][wayBits-1:0] newAges
);

    always_comb begin
        newAges = ages;
        for (int w = 0; w < ways; w++) begin
            if (wayBits'(w) == touchWay) begin
                newAges[w] = '0;
            end else if (ages[w] < ages[touchWay]) begin
                newAges[w] = ages[w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tag_fill_controller.sv
// Miss allocation for a set-associative tag store: picks a victim,
// writes back dirty victims, installs the new tag and keeps LRU ages.
module tag_fill_controller
    import cache_pkg::*;
#(
    parameter int tagBits   = TagBitsDef,
    parameter int indexBits = IndexBitsDef,
    parameter int ways      = WaysDef,
    localparam int wayBits  = $clog2(ways)
) (
    input  logic                      clk,
    input  logic                      reset,
    tag_fill_controller_if.slave      bus,
    input  logic                      hitValid,
    input  logic [indexBits-1:0]      hitIndex,
    input  logic [wayBits-1:0]        hitWay,
    input  logic [indexBits-1:0]      lookupIndex,
    output logic [ways*tagBits-1:0]   cacheTag,
    output logic [ways-1:0]           cacheValid
);

    localparam int sets = 1 << indexBits;

    typedef logic [ways-1:0][wayBits-1:0] ageVec_t;

    logic [ways-1:0]              validArr [sets];
    logic [ways-1:0]              dirtyArr [sets];
    logic [ways-1:0][tagBits-1:0] tagArr   [sets];
    ageVec_t                      ageArr   [sets];

    fillState_e           state, nextState;
    logic [tagBits-1:0]   latTag;
    logic [indexBits-1:0] latIndex;
    logic                 latDirty;
    logic [wayBits-1:0]   victimWay;
    logic [tagBits-1:0]   victimTag;
    logic [wayBits-1:0]   selWay;
    logic                 needEvict;
    logic                 hitApply;
    ageVec_t              hitAgesNew;
    ageVec_t              fillAgesNew;

    // Invalid ways win over the oldest way; the lowest invalid index wins.
    always_comb begin
        selWay = '0;
        for (int w = ways - 1; w >= 0; w--) begin
            if (ageArr[latIndex][w] == wayBits'(ways - 1)) selWay = wayBits'(w);
        end
        for (int w = ways - 1; w >= 0; w--) begin
            if (!validArr[latIndex][w]) selWay = wayBits'(w);
        end
    end

    assign needEvict = validArr[latIndex][selWay] && dirtyArr[latIndex][selWay];
    assign hitApply  = hitValid && !(state == WRITE && hitIndex == latIndex);

    lru_age_update #(.ways(ways)) uHitAge (
        .ages     (ageArr[hitIndex]),
        .touchWay (hitWay),
        .newAges  (hitAgesNew)
    );

    lru_age_update #(.ways(ways)) uFillAge (
        .ages     (ageArr[latIndex]),
        .touchWay (victimWay),
        .newAges  (fillAgesNew)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState      = state;
        bus.fillReady  = 1'b0;
        bus.fillDone   = 1'b0;
        bus.fillWay    = '0;
        bus.evictValid = 1'b0;
        bus.evictTag   = '0;
        bus.evictIndex = '0;
        unique case (state)
            IDLE: begin
                bus.fillReady = 1'b1;
                if (bus.fillReq) nextState = SELECT;
            end
            SELECT: nextState = needEvict ? EVICT : WRITE;
            EVICT: begin
                bus.evictValid = 1'b1;
                bus.evictTag   = victimTag;
                bus.evictIndex = latIndex;
                if (bus.evictReady) nextState = WRITE;
            end
            WRITE: nextState = DONE;
            DONE: begin
                bus.fillDone = 1'b1;
                bus.fillWay  = victimWay;
                nextState    = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latTag    <= '0;
            latIndex  <= '0;
            latDirty  <= 1'b0;
            victimWay <= '0;
            victimTag <= '0;
        end else begin
            if (state == IDLE && bus.fillReq) begin
                latTag   <= bus.fillTag;
                latIndex <= bus.fillIndex;
                latDirty <= bus.fillDirty;
            end
            if (state == SELECT) begin
                victimWay <= selWay;
                victimTag <= tagArr[latIndex][selWay];
            end
        end
    end

    // A same-set hit in WRITE is dropped, so the two age writes never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < sets; s++) begin
                validArr[s] <= '0;
                dirtyArr[s] <= '0;
                tagArr[s]   <= '0;
                for (int w = 0; w < ways; w++) begin
                    ageArr[s][w] <= wayBits'(w);
                end
            end
        end else begin
            if (hitApply) ageArr[hitIndex] <= hitAgesNew;
            if (state == WRITE) begin
                validArr[latIndex][victimWay] <= 1'b1;
                dirtyArr[latIndex][victimWay] <= latDirty;
                tagArr[latIndex][victimWay]   <= latTag;
                ageArr[latIndex]              <= fillAgesNew;
            end
        end
    end

    assign cacheTag   = tagArr[lookupIndex];
    assign cacheValid = validArr[lookupIndex];

endmodule

// File: tb/tb_tag_fill_controller.sv
// Scoreboard bench for tag_fill_controller: directed scenarios plus
// random traffic against a recency-list reference model.
module tb_tag_fill_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        hitValid;
    logic [3:0]  hitIndex;
    logic [1:0]  hitWay;
    logic [3:0]  lookupIndex;
    logic [47:0] cacheTag;
    logic [3:0]  cacheValid;

    tag_fill_controller_if bus ();

    tag_fill_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .hitValid    (hitValid),
        .hitIndex    (hitIndex),
        .hitWay      (hitWay),
        .lookupIndex (lookupIndex),
        .cacheTag    (cacheTag),
        .cacheValid  (cacheValid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon = 0;

    // Reference model: mOrd[s][0] is most recent, mOrd[s][3] least recent.
    bit mValid [16][4];
    bit mDirty [16][4];
    int mTag   [16][4];
    int mOrd   [16][4];
    int mp;
    int lt, li, vw;
    bit ld;
    int doneQ[$];
    int evTagQ[$];
    int evIdxQ[$];

    int lastWay = -1;
    int lastEvTag = -1;
    int lastEvIdx = -1;
    int evCount = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic void touch(int s, int w);
        int p = 0;
        for (int i = 0; i < 4; i++) if (mOrd[s][i] == w) p = i;
        for (int i = p; i > 0; i--) mOrd[s][i] = mOrd[s][i-1];
        mOrd[s][0] = w;
    endfunction

    function automatic void modelReset();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) begin
                mValid[s][w] = 0;
                mDirty[s][w] = 0;
                mTag[s][w]   = 0;
                mOrd[s][w]   = w;
            end
        end
        mp = 0;
        doneQ.delete();
        evTagQ.delete();
        evIdxQ.delete();
    endfunction

    function automatic int pickVictim(int s);
        for (int w = 0; w < 4; w++) if (!mValid[s][w]) return w;
        return mOrd[s][3];
    endfunction

    task automatic cyc(bit rs, bit fr, int tg, int ix, bit dt,
                       bit hv, int hi, int hw, bit er, int lk);
        int old;
        reset          = rs;
        bus.fillReq    = fr;
        bus.fillTag    = 12'(tg);
        bus.fillIndex  = 4'(ix);
        bus.fillDirty  = dt;
        hitValid       = hv;
        hitIndex       = 4'(hi);
        hitWay         = 2'(hw);
        bus.evictReady = er;
        lookupIndex    = 4'(lk);
        @(posedge clk);
        old = mp;
        if (rs) begin
            modelReset();
        end else begin
            case (old)
                0: if (fr) begin
                    lt = tg & 'hfff; li = ix; ld = dt; mp = 1;
                end
                1: begin
                    vw = pickVictim(li);
                    doneQ.push_back(vw);
                    if (mValid[li][vw] && mDirty[li][vw]) begin
                        evTagQ.push_back(mTag[li][vw]);
                        evIdxQ.push_back(li);
                        mp = 2;
                    end else begin
                        mp = 3;
                    end
                end
                2: if (er) mp = 3;
                3: begin
                    mValid[li][vw] = 1;
                    mDirty[li][vw] = ld;
                    mTag[li][vw]   = lt;
                    touch(li, vw);
                    mp = 4;
                end
                default: mp = 0;
            endcase
            if (hv && !(old == 3 && hi == li)) touch(hi, hw);
        end
        #2;
    endtask

    task automatic idle(int lk);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, lk);
    endtask

    task automatic rst();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic fill(int tg, int ix, bit dt, int erLow, bit hitW, int hw);
        int k = 0;
        cyc(0, 1, tg, ix, dt, 0, 0, 0, 1, ix);
        for (int n = 0; n < 40; n++) begin
            bit er;
            bit hv;
            if (mp == 0) break;
            er = 1;
            if (mp == 2) begin
                er = (k >= erLow);
                k++;
            end
            hv = hitW && (mp == 3);
            cyc(0, 1'($urandom_range(0, 1)), $urandom_range(0, 4095),
                $urandom_range(0, 15), 1, hv, ix, hw, er, ix);
        end
        if (mp != 0) begin
            checks++;
            errors++;
            $display("FAIL fillTimeout act=%0d exp=0", mp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [47:0] et;
        logic [3:0]  ev;
        int          e;
        if (mon) begin
            for (int w = 0; w < 4; w++) begin
                et[w*12 +: 12] = 12'(mTag[lookupIndex][w]);
                ev[w]          = mValid[lookupIndex][w];
            end
            chk("cacheTag", cacheTag, et);
            chk("cacheValid", cacheValid, ev);
            chk("fillReady", bus.fillReady, mp == 0);
            chk("fillDone", bus.fillDone, mp == 4);
            chk("evictValid", bus.evictValid, mp == 2);
            if (bus.fillDone) begin
                if (doneQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fillDoneUnexpected act=1 exp=0");
                end else begin
                    e = doneQ.pop_front();
                    chk("fillWay", bus.fillWay, e);
                    lastWay = bus.fillWay;
                end
            end
            if (bus.evictValid) begin
                if (evTagQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evictUnexpected act=1 exp=0");
                end else begin
                    chk("evictTag", bus.evictTag, evTagQ[0]);
                    chk("evictIndex", bus.evictIndex, evIdxQ[0]);
                    if (bus.evictReady) begin
                        lastEvTag = bus.evictTag;
                        lastEvIdx = bus.evictIndex;
                        evCount++;
                        void'(evTagQ.pop_front());
                        void'(evIdxQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int e0;
        modelReset();
        rst();
        rst();
        mon = 1;
        chk("rstReady", bus.fillReady, 1);
        chk("rstDone", bus.fillDone, 0);
        chk("rstWay", bus.fillWay, 0);
        chk("rstEvictValid", bus.evictValid, 0);
        chk("rstEvictTag", bus.evictTag, 0);
        chk("rstEvictIndex", bus.evictIndex, 0);
        chk("rstCacheValid", cacheValid, 0);

        fill('h123, 5, 0, 0, 0, 0);
        chk("r35Way", lastWay, 0);
        idle(5);
        chk("r35Tag", cacheTag[11:0], 'h123);

        rst();
        for (int i = 0; i < 4; i++) fill('h200 + i, 2, 0, 0, 0, 0);
        e0 = evCount;
        fill('h204, 2, 0, 0, 0, 0);
        chk("r36Way", lastWay, 0);
        chk("r36NoEvict", evCount, e0);

        rst();
        for (int i = 0; i < 4; i++) fill('hA00 + i, 2, 1, 0, 0, 0);
        fill('hA04, 2, 1, 3, 0, 0);
        chk("r37EvTag", lastEvTag, 'hA00);
        chk("r37EvIdx", lastEvIdx, 2);
        chk("r37Way", lastWay, 0);

        rst();
        for (int i = 0; i < 4; i++) fill('h700 + i, 7, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 7, 0, 1, 7);
        fill('h704, 7, 0, 0, 0, 0);
        chk("r38Way", lastWay, 1);

        rst();
        for (int i = 0; i < 4; i++) fill('h300 + i, 3, 0, 0, 0, 0);
        fill('h304, 3, 0, 0, 1, 1);
        chk("r40Way", lastWay, 0);
        fill('h305, 3, 0, 0, 0, 0);
        chk("r40Next", lastWay, 1);

        rst();
        for (int i = 0; i < 4; i++) fill('h100 + i, 1, 1, 0, 0, 0);
        cyc(0, 1, 'h105, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("r39InEvict", bus.evictValid, 1);
        rst();
        chk("r39EvictValid", bus.evictValid, 0);
        chk("r39Ready", bus.fillReady, 1);
        for (int i = 0; i < 16; i++) begin
            idle(i);
            chk("r39CacheValid", cacheValid, 0);
        end

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 399) == 0,
                $urandom_range(0, 1),
                $urandom_range(0, 4095),
                $urandom_range(0, 3),
                $urandom_range(0, 1),
                $urandom_range(0, 9) < 3,
                $urandom_range(0, 3),
                $urandom_range(0, 3),
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 3));
        end
        for (int n = 0; n < 40 && mp != 0; n++) idle(0);
        if (mp != 0) begin
            checks++;
            errors++;
            $display("FAIL drainTimeout act=%0d exp=0", mp);
        end
        idle(0);
        mon = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tag_fill_controller.md
TAG_FILL_CONTROLLER -- requirements
Module: tag_fill_controller

Interface
REQ-001 Parameter tagBits, default 12, address tag width.
REQ-002 Parameter indexBits, default 4, set index width (16 sets).
REQ-003 Parameter ways, default 4, associativity; power of two; wayBits = log2(ways).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 fillReq  in  1  miss allocation request; accepted when fillReq and fillReady are both high.
REQ-008 fillTag, fillIndex, fillDirty  in  tagBits/indexBits/1  new line tag, target set, initial dirty bit.
REQ-009 fillReady  out  1  high only in IDLE.
REQ-010 fillDone, fillWay  out  1/wayBits  one-cycle completion pulse and the way written.
REQ-011 evictValid, evictTag, evictIndex  out  1/tagBits/indexBits  dirty victim writeback request.
REQ-012 evictReady  in  1  memory side accepts the eviction when evictValid and evictReady are both high.
REQ-013 hitValid, hitIndex, hitWay  in  1/indexBits/wayBits  lookup hit, used only for the LRU touch.
REQ-014 lookupIndex  in  indexBits; cacheTag, cacheValid  out  ways*tagBits/ways  combinational read of the addressed set for the tag comparators.

Function
REQ-015 Per set and way, the block SHALL store valid, dirty, tag and a wayBits-wide LRU age; ages in a set SHALL always form a permutation of 0..ways-1.
REQ-016 FSM states: IDLE, SELECT, EVICT, WRITE, DONE.
REQ-017 IDLE->SELECT on an accepted request; fillTag, fillIndex and fillDirty SHALL be latched at acceptance.
REQ-018 SELECT, one cycle: victim = lowest-numbered invalid way; if all ways are valid, victim = the way with age ways-1.
REQ-019 SELECT->EVICT if the victim is valid and dirty; otherwise SELECT->WRITE.
REQ-020 EVICT: evictValid=1 with the victim tag and latched index, held stable until the handshake; on handshake ->WRITE.
REQ-021 WRITE, one cycle: victim way gets valid=1, tag=latched tag, dirty=latched fillDirty, and is touched to MRU; ->DONE.
REQ-022 DONE: fillDone=1 and fillWay=victim for exactly one cycle; ->IDLE.
REQ-023 Minimum request-to-fillDone latency SHALL be 3 cycles (clean victim); EVICT adds one cycle per cycle evictReady is low, plus one.
REQ-024 Touching way w: age[w]<-0; ways with age < old age[w] increment by 1; all other ways unchanged.
REQ-025 hitValid SHALL touch hitWay in hitIndex in every state, except in WRITE when hitIndex equals the latched index, where the hit is dropped and the fill touch applies.
REQ-026 A hit touch on a set under eviction in SELECT or EVICT SHALL NOT change the chosen victim.
REQ-027 cacheTag and cacheValid SHALL reflect state written at the previous clock edge, with no bypass.
REQ-028 fillReq while fillReady is low SHALL be ignored and not queued.

Reset
REQ-029 Reset SHALL have priority over all inputs and apply in any state, including EVICT with evictValid high; the pending eviction is abandoned.
REQ-030 After reset, all valid=0, dirty=0 and tag=0; age of way w in every set = w; state = IDLE.
REQ-031 Output values during and after reset: fillReady=1 (IDLE), fillDone=0, fillWay=0, evictValid=0, evictTag=0, evictIndex=0.

Structure
REQ-032 Package cache_pkg SHALL hold the default tagBits, indexBits and ways values and the FSM state enum typedef.
REQ-033 Sub-module lru_age_update SHALL implement the combinational age update for one set (inputs: current ages and touched way; output: new ages).
REQ-034 The tag, valid, dirty and age arrays SHALL be flops, not inferred RAM, to allow the same-cycle reset clear.

Verification
REQ-035 After reset, fill tag 0x123 into index 5 with fillDirty=0 -> fillDone 3 cycles after acceptance, fillWay=0, cacheTag[0]=0x123 at lookupIndex=5.
REQ-036 Fill 4 clean tags into index 2, then a 5th -> victim = way 0 (oldest), evictValid stays 0, fillWay=0.
REQ-037 Fill 4 dirty tags into index 2, hold evictReady=0 for 3 cycles, then fill a 5th -> evictValid held with evictTag=first tag and evictIndex=2 until evictReady rises; fillDone follows 2 cycles later.
REQ-038 Fill ways 0-3 of index 7, hit way 0, then fill -> victim = way 1; every set's ages remain a permutation of 0..3.
REQ-039 Assert reset while in EVICT -> next cycle evictValid=0, fillReady=1 and all cacheValid bits are 0.
REQ-040 Hit on the same index as the fill during WRITE -> the filled way gets age 0 and the hit is dropped; fillReq asserted during busy states is ignored.
